stack_ptr_ctrl: RTL
===================

STACK_PTR_CTRL -- requirements
Module: stack_ptr_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_MAX, default 31, giving the counter value treated as full (range 1..31).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port push_req  input  1  push request, held high until push_ack.
REQ-005 The block SHALL have port pop_req  input  1  pop request, held high until pop_ack.
REQ-006 The block SHALL have port clr_req  input  1  clear request, held high until clr_ack.
REQ-007 The block SHALL have port cnt_val  input  5  current value of the 5-bit up/down counter.
REQ-008 The block SHALL have port down_done  input  1  counter-is-zero status from the counter.
REQ-009 The block SHALL have port cntU  output  1  count-up pulse to the counter.
REQ-010 The block SHALL have port cntD  output  1  count-down pulse to the counter.
REQ-011 The block SHALL have port rst5  output  1  clear pulse to the counter.
REQ-012 The block SHALL have ports push_ack, pop_ack and clr_ack  output  1 each  one-cycle completion strobes.
REQ-013 The block SHALL have port refused  output  1  high with an ack when the operation was not performed.
REQ-014 The block SHALL have ports full and empty  output  1 each  registered occupancy flags.
REQ-015 The block SHALL have port err  output  1  sticky overflow/underflow flag.
REQ-016 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC, SETTLE and ACK, with transitions IDLE->EXEC on any request, EXEC->SETTLE, SETTLE->ACK and ACK->IDLE unconditionally.
REQ-018 In IDLE, the block SHALL select one request with fixed priority clr > pop > push and latch the operation at the transition edge.
REQ-019 At the IDLE->EXEC edge, the block SHALL latch a refuse bit: push with cnt_val == DEPTH_MAX, or pop with down_done == 1; clear is never refused.
REQ-020 In EXEC, the block SHALL assert exactly one of cntU, cntD or rst5 for exactly one cycle, selected by the latched operation, and SHALL assert none when the refuse bit is set.
REQ-021 cntU, cntD and rst5 SHALL be low in every state other than EXEC and SHALL never be high simultaneously.
REQ-022 SETTLE SHALL exist so that cnt_val reflects the update; at the SETTLE->ACK edge, the block SHALL register full = (cnt_val == DEPTH_MAX) and empty = down_done.
REQ-023 In ACK, the block SHALL raise the ack matching the latched operation for one cycle, and SHALL drive refused equal to the refuse bit during that cycle, with refused low otherwise.
REQ-024 Latency SHALL be fixed: a request first seen high in IDLE at cycle 0 produces the counter pulse in cycle 1 and the ack in cycle 3, with IDLE in cycle 4.
REQ-025 Requests that are not selected SHALL be ignored until the next IDLE and SHALL NOT be lost as long as they are held.
REQ-026 A request still high in the cycle after its ack SHALL be treated as a new request, one operation per four cycles.
REQ-027 err SHALL be set at the ACK cycle of any refused push or pop and SHALL be cleared only by a completed clear operation or by rst.
REQ-028 Request changes outside IDLE SHALL NOT alter the latched operation.

Reset
REQ-029 While rst is high at a clock edge, the state SHALL go to IDLE, and the latched operation and refuse bit SHALL clear.
REQ-030 While rst is high, cntU, cntD, rst5, all acks, refused, err and busy SHALL go to 0, full SHALL go to 0, and empty SHALL go to 1.
REQ-031 A reset asserted mid-operation SHALL abort that operation with no ack; a counter pulse already issued in EXEC is not undone.

Verification
REQ-032 The bench SHALL cover push from empty: with cnt_val = 0, hold push_req -> cntU high in cycle 1 only, push_ack with refused = 0 in cycle 3, cnt_val = 1, empty = 0.
REQ-033 The bench SHALL cover pop on empty: with cnt_val = 0 and down_done = 1, pulse pop_req -> no cntD, pop_ack with refused = 1 in cycle 3, err = 1.
REQ-034 The bench SHALL cover push at full: with cnt_val = 31 (DEPTH_MAX = 31), push_req -> no cntU, refused = 1, full = 1, err = 1, then clr_req -> rst5 pulse, clr_ack, cnt_val = 0, err = 0, empty = 1.
REQ-035 The bench SHALL cover simultaneous requests: push_req, pop_req and clr_req all high at cnt_val = 5 -> clear served first, then pop refused because the counter is empty, then push to 1, with acks at cycles 3, 7 and 11.
REQ-036 The bench SHALL cover back-to-back pushes: push_req held for 32 operations from 0 -> 31 acks with refused = 0, the 32nd with refused = 1, and cnt_val ends at 31.
REQ-037 The bench SHALL cover reset mid-operation: rst high in SETTLE of a push -> no push_ack, busy = 0, and all outputs at reset values the next cycle.

Source files
------------

// File: rtl/stack_ptr_ctrl.sv
// Push/pop/clear sequencer for an external 5-bit up/down stack-pointer counter.
// Each operation takes four cycles: select, pulse the counter, settle, acknowledge.
//
// state  | meaning
// IDLE   | waiting; selects clr > pop > push and latches op + refuse bit
// EXEC   | one-cycle counter pulse for the latched op (none if refused)
// SETTLE | counter output settles; occupancy flags captured on exit
// ACK    | one-cycle ack for the latched op, refused shows refuse bit
module stack_ptr_ctrl #(
  parameter int unsigned DEPTH_MAX = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_req,
  input  logic       pop_req,
  input  logic       clr_req,
  input  logic [4:0] cnt_val,
  input  logic       down_done,
  output logic       cntU,
  output logic       cntD,
  output logic       rst5,
  output logic       push_ack,
  output logic       pop_ack,
  output logic       clr_ack,
  output logic       refused,
  output logic       full,
  output logic       empty,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, SETTLE, ACK} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_CLR} op_t;

  localparam logic [4:0] DEPTH_VAL = 5'(DEPTH_MAX);

  state_t state_q, state_d;
  op_t    op_q, op_d;
  logic   refuse_q, refuse_d;
  logic   full_q, full_d;
  logic   empty_q, empty_d;
  logic   err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_NONE;
      refuse_q <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      refuse_q <= refuse_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    refuse_d = refuse_q;
    full_d   = full_q;
    empty_d  = empty_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          op_d     = OP_CLR;
          refuse_d = 1'b0;
          state_d  = EXEC;
        end else if (pop_req) begin
          op_d     = OP_POP;
          refuse_d = down_done;
          state_d  = EXEC;
        end else if (push_req) begin
          op_d     = OP_PUSH;
          refuse_d = (cnt_val == DEPTH_VAL);
          state_d  = EXEC;
        end
      end
      EXEC: state_d = SETTLE;
      SETTLE: begin
        // counter has absorbed the EXEC pulse by now, so flags are current
        state_d = ACK;
        full_d  = (cnt_val == DEPTH_VAL);
        empty_d = down_done;
        if (op_q == OP_CLR) err_d = 1'b0;
        else if (refuse_q)  err_d = 1'b1;
      end
      ACK: begin
        state_d  = IDLE;
        op_d     = OP_NONE;
        refuse_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  logic do_pulse;
  assign do_pulse = (state_q == EXEC) && !refuse_q;
  assign cntU     = do_pulse && (op_q == OP_PUSH);
  assign cntD     = do_pulse && (op_q == OP_POP);
  assign rst5     = do_pulse && (op_q == OP_CLR);

  assign push_ack = (state_q == ACK) && (op_q == OP_PUSH);
  assign pop_ack  = (state_q == ACK) && (op_q == OP_POP);
  assign clr_ack  = (state_q == ACK) && (op_q == OP_CLR);
  assign refused  = (state_q == ACK) && refuse_q;

  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule
